layer_sequencer: RTL and testbench

Controller that runs a multi-layer perceptron through one shared, sequential neural-layer datapath (matrix-vector multiply, bias add, activation), one layer at a time. It fetches each layer's weights and bias from the parameter store, feeds the current activation vector to the datapath, waits for completion, and latches the result back as the next layer's input. It sits between the network top level, which handles start and result, and the single layer datapath instance.

---
 rtl/layer_sequencer_pkg.sv | 15 +
 rtl/layer_sequencer_settle_timer.sv | 18 +
 rtl/layer_sequencer.sv | 103 ++++++++++
 tb/tb_layer_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sequencer_pkg.sv
// layer_sequencer_pkg: shared state encoding, float width and index-width helper
package layer_sequencer_pkg;
    localparam int FP_W = 32;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RUN,
        ST_SETTLE,
        ST_STORE,
        ST_FINISH
    } state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/layer_sequencer_settle_timer.sv
// settle_timer: loadable down-counter that stops at zero and flags it
module settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    assign zero = (cnt == '0);
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs an MLP layer by layer through one shared datapath.
// Define LAYER_TIMEOUT_EN to add a FETCH/RUN watchdog and the sticky err output.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int VEC_SIZE   = 4,
    parameter int SETTLE     = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [FP_W*VEC_SIZE-1:0]      in_vec,
    output logic                          busy,
    output logic                          done,
    output logic [FP_W*VEC_SIZE-1:0]      out_vec,
    output logic                          param_req,
    output logic [idx_w(NUM_LAYERS)-1:0]  param_layer,
    input  logic                          param_ack,
    output logic [FP_W*VEC_SIZE-1:0]      lyr_in,
    output logic                          lyr_start,
    input  logic                          lyr_done,
    input  logic [FP_W*VEC_SIZE-1:0]      lyr_result
`ifdef LAYER_TIMEOUT_EN
    ,
    output logic                          err
`endif
);
    localparam int LW = idx_w(NUM_LAYERS);
    localparam int SW = idx_w(SETTLE + 1);
    localparam logic [LW-1:0] LAST = LW'(NUM_LAYERS - 1);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE > 0 ? SETTLE - 1 : 0);

    state_t state, state_nx;
    logic [LW-1:0] layer;
    logic [FP_W*VEC_SIZE-1:0] act;
    logic settle_zero, timed_out;

    settle_timer #(.W(SW)) u_settle (
        .clk(clk), .rst_n(rst_n), .load(state == ST_RUN && lyr_done),
        .en(state == ST_SETTLE), .load_val(SETTLE_LD), .zero(settle_zero)
    );

`ifdef LAYER_TIMEOUT_EN
    localparam int TW = idx_w(TIMEOUT + 1);
    logic wd_zero;
    // Reloaded on every state change, so it only measures time spent in one state.
    settle_timer #(.W(TW)) u_watchdog (
        .clk(clk), .rst_n(rst_n), .load(state_nx != state),
        .en(state == ST_FETCH || state == ST_RUN), .load_val(TW'(TIMEOUT - 1)), .zero(wd_zero)
    );
    assign timed_out = wd_zero && (state == ST_FETCH || state == ST_RUN);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err <= 1'b0;
        else if (state == ST_IDLE && start) err <= 1'b0;
        else if (timed_out) err <= 1'b1;
`else
    assign timed_out = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   state_nx = start ? ST_FETCH : ST_IDLE;
            ST_FETCH:  state_nx = timed_out ? ST_FINISH : param_ack ? ST_RUN : ST_FETCH;
            ST_RUN:    state_nx = timed_out ? ST_FINISH : !lyr_done ? ST_RUN :
                                  (SETTLE == 0) ? ST_STORE : ST_SETTLE;
            ST_SETTLE: state_nx = settle_zero ? ST_STORE : ST_SETTLE;
            ST_STORE:  state_nx = (layer == LAST) ? ST_FINISH : ST_FETCH;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            layer     <= '0;
            act       <= '0;
            out_vec   <= '0;
            lyr_start <= 1'b0;
        end else begin
            lyr_start <= state == ST_FETCH && param_ack && !timed_out;
            if (state == ST_IDLE && start) begin
                act   <= in_vec;
                layer <= '0;
            end
            if (state == ST_STORE) begin
                act <= lyr_result;
                if (layer == LAST) out_vec <= lyr_result;
                else layer <= layer + 1'b1;
            end
        end

    assign busy        = state != ST_IDLE && state != ST_FINISH;
    assign done        = state == ST_FINISH;
    assign param_req   = state == ST_FETCH;
    assign param_layer = layer;
    assign lyr_in      = act;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed checks of layer_sequencer (3-layer default and a 1-layer SETTLE=0 instance)
module tb_layer_sequencer;
    localparam int V = 4;
    localparam int W = 32 * V;
    localparam logic [31:0] F1 = 32'h3F800000, F2 = 32'h40000000, F3 = 32'h40400000,
                            F4 = 32'h40800000, F5 = 32'h40A00000;

    logic clk = 0, rst_n = 0, start = 0, param_ack = 0;
    logic [W-1:0] in_vec = '0, out_vec, lyr_in, lyr_result = '0;
    logic busy, done, param_req, lyr_start, lyr_done;
    logic [1:0] param_layer;
    logic start2 = 0, ack2 = 1, ldone2 = 1, busy2, done2, req2, lstart2;
    logic [0:0] layer2;
    logic [W-1:0] in2 = {F4, F3, F2, F1}, res2 = 128'h0123456789ABCDEF_FEDCBA9876543210, out2, lin2;
`ifdef LAYER_TIMEOUT_EN
    logic err, err2;
`endif

    always #5 clk = ~clk;

    layer_sequencer #(.NUM_LAYERS(3), .VEC_SIZE(V), .SETTLE(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_vec(in_vec), .busy(busy), .done(done),
        .out_vec(out_vec), .param_req(param_req), .param_layer(param_layer), .param_ack(param_ack),
        .lyr_in(lyr_in), .lyr_start(lyr_start), .lyr_done(lyr_done), .lyr_result(lyr_result)
`ifdef LAYER_TIMEOUT_EN
        , .err(err)
`endif
    );

    layer_sequencer #(.NUM_LAYERS(1), .VEC_SIZE(V), .SETTLE(0), .TIMEOUT(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_vec(in2), .busy(busy2), .done(done2),
        .out_vec(out2), .param_req(req2), .param_layer(layer2), .param_ack(ack2),
        .lyr_in(lin2), .lyr_start(lstart2), .lyr_done(ldone2), .lyr_result(res2)
`ifdef LAYER_TIMEOUT_EN
        , .err(err2)
`endif
    );

    function automatic logic [31:0] inc1(input logic [31:0] x);
        return x == F1 ? F2 : x == F2 ? F3 : x == F3 ? F4 : x == F4 ? F5 : 32'hFFFFFFFF;
    endfunction
    function automatic logic [W-1:0] vinc(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < V; i++) r[32*i +: 32] = inc1(v[32*i +: 32]);
        return r;
    endfunction

    // Datapath model: +1.0 per element, done pulse 3 cycles after the start pulse.
    logic [2:0] mcnt = 0;
    bit block_done = 0;
    always @(posedge clk)
        if (lyr_start) begin
            lyr_result <= vinc(lyr_in);
            mcnt <= 3;
        end else if (mcnt != 0) mcnt <= mcnt - 1;
    assign lyr_done = mcnt == 1 && !block_done;

    // Parameter store responder plus event counters.
    int n_start = 0, n_done = 0, viol = 0, req_cnt = 0, cur_len = 0;
    int req_len[3] = '{0, 0, 0};
    int ack_dly[3] = '{0, 0, 0};
    logic [1:0] req_lyr = 0;
    bit prev_acc = 0;
    always @(negedge clk) begin
        if (lyr_start) begin
            n_start++;
            if (!prev_acc) viol++;
        end
        if (done) n_done++;
        if (param_req) begin
            param_ack = (req_cnt >= ack_dly[param_layer]);
            req_cnt++;
            cur_len++;
            req_lyr = param_layer;
        end else begin
            param_ack = 0;
            req_cnt = 0;
            if (cur_len != 0) req_len[req_lyr] = cur_len;
            cur_len = 0;
        end
        prev_acc = param_req && param_ack;
    end

    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [W-1:0] v);
        @(negedge clk);
        in_vec = v;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < lim);
        chk("done_seen", done, 1);
    endtask

    int n, s0, d0;
    bit found;
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", param_req, 0);
        chk("rst_lstart", lyr_start, 0);
        chk("rst_out", out_vec, 0);
        chk("rst_lyr_in", lyr_in, 0);
        chk("rst_layer", param_layer, 0);
        rst_n = 1;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_busy2", busy2, 0);

        // Three layers of +1.0, immediate acks.
        s0 = n_start; d0 = n_done;
        do_start({4{F1}});
        chk("a_req", param_req, 1);
        chk("a_layer0", param_layer, 0);
        chk("a_busy", busy, 1);
        chk("a_lyr_in", lyr_in, {4{F1}});
        chk("a_lstart_early", lyr_start, 0);
        @(negedge clk);
        chk("a_lstart", lyr_start, 1);
        chk("a_req_drop", param_req, 0);
        @(negedge clk);
        chk("a_lstart_width", lyr_start, 0);
        wait_done(100, n);
        chk("a_latency", n, 22);
        chk("a_busy_at_done", busy, 0);
        chk("a_out", out_vec, {4{F4}});
`ifdef LAYER_TIMEOUT_EN
        chk("a_err", err, 0);
`endif
        @(negedge clk);
        chk("a_done_width", done, 0);
        chk("a_nstart", n_start - s0, 3);
        chk("a_ndone", n_done - d0, 1);

        // Layer 1 parameters arrive 5 cycles late.
        s0 = n_start;
        ack_dly[1] = 5;
        do_start({4{F2}});
        wait_done(100, n);
        chk("b_latency", n, 29);
        chk("b_out", out_vec, {4{F5}});
        @(negedge clk);
        ack_dly[1] = 0;
        chk("b_req_len1", req_len[1], 6);
        chk("b_req_len0", req_len[0], 1);
        chk("b_req_len2", req_len[2], 1);
        chk("b_early_lstart", viol, 0);
        chk("b_nstart", n_start - s0, 3);

        // Start pulsed during RUN is ignored.
        s0 = n_start; d0 = n_done;
        do_start({4{F1}});
        @(negedge clk);
        in_vec = {4{F3}};
        start = 1;
        @(negedge clk);
        start = 0;
        chk("c_lyr_in", lyr_in, {4{F1}});
        chk("c_busy", busy, 1);
        wait_done(100, n);
        chk("c_latency", n, 22);
        chk("c_out", out_vec, {4{F4}});
        @(negedge clk);
        chk("c_ndone", n_done - d0, 1);
        chk("c_nstart", n_start - s0, 3);

        // Reset during SETTLE of layer 2, then a clean rerun.
        d0 = n_done;
        do_start({4{F2}});
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = lyr_done && param_layer == 2;
        end
        chk("d_reach_l2", found, 1);
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("d_busy", busy, 0);
        chk("d_done", done, 0);
        chk("d_req", param_req, 0);
        chk("d_lstart", lyr_start, 0);
        chk("d_out", out_vec, 0);
        chk("d_lyr_in", lyr_in, 0);
        chk("d_layer", param_layer, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        chk("d_no_done", n_done - d0, 0);
        do_start({4{F2}});
        wait_done(100, n);
        chk("d_latency", n, 24);
        chk("d_out2", out_vec, {4{F5}});
        @(negedge clk);

`ifdef LAYER_TIMEOUT_EN
        // Datapath never completes: watchdog fires after 16 RUN cycles.
        block_done = 1;
        do_start({4{F1}});
        @(negedge clk);
        chk("t_lstart", lyr_start, 1);
        wait_done(100, n);
        chk("t_run_cycles", n, 16);
        chk("t_err", err, 1);
        chk("t_out_kept", out_vec, {4{F5}});
        @(negedge clk);
        block_done = 0;
        chk("t_err_sticky", err, 1);
        do_start({4{F1}});
        chk("t_err_clr", err, 0);
        wait_done(100, n);
        chk("t_out", out_vec, {4{F4}});
        @(negedge clk);
`endif

        // SETTLE=0 single-layer instance: lyr_done already high on the first RUN cycle.
        @(negedge clk);
        start2 = 1;
        @(negedge clk);
        start2 = 0;
        chk("s0_req", req2, 1);
        @(negedge clk);
        chk("s0_lstart", lstart2, 1);
        chk("s0_lyr_in", lin2, in2);
        @(negedge clk);
        chk("s0_store_busy", busy2, 1);
        chk("s0_store_done", done2, 0);
        chk("s0_store_out", out2, 0);
        @(negedge clk);
        chk("s0_done", done2, 1);
        chk("s0_out", out2, res2);
        chk("s0_busy", busy2, 0);
        @(negedge clk);
        chk("s0_done_width", done2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
